// File: rtl/hedios_tx_arbiter_if.sv
// Requester/TX-queue bundle for the HEDIOS TX arbiter.
// master = requester/queue side, slave = arbiter side.
interface hedios_tx_arbiter_if #(
  parameter int REQ_COUNT = 2
);
  localparam int IDX_W = $clog2(REQ_COUNT);

  logic [REQ_COUNT-1:0]       req_valid;
  logic [REQ_COUNT-1:0]       req_lock;
  logic [REQ_COUNT-1:0][7:0]  req_command;
  logic [REQ_COUNT-1:0][31:0] req_data;
  logic [REQ_COUNT-1:0]       req_ack;
  logic                       tx_full;
  logic [7:0]                 tx_command;
  logic [31:0]                tx_data;
  logic                       tx_push_packet;
  logic [IDX_W-1:0]           grant_owner;
  logic                       busy;

  modport master (
    output req_valid, req_lock, req_command, req_data, tx_full,
    input  req_ack, tx_command, tx_data, tx_push_packet, grant_owner, busy
  );

  modport slave (
    input  req_valid, req_lock, req_command, req_data, tx_full,
    output req_ack, tx_command, tx_data, tx_push_packet, grant_owner, busy
  );
endinterface

// File: rtl/hedios_tx_arbiter.sv
// Round-robin arbiter with optional locked bursts feeding one serial TX queue.
// A grant captures the packet; the following PUSH cycle strobes it out and acks it.
module hedios_tx_arbiter #(
  parameter int REQ_COUNT = 2,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  hedios_tx_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(REQ_COUNT);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PUSH   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t               state_reg;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [IDX_W-1:0]     owner_reg;
  logic [CNT_W-1:0]     burst_cnt_reg;
  logic                 lock_flag_reg;
  logic                 push_reg;
  logic [REQ_COUNT-1:0] ack_reg;
  logic [7:0]           command_reg;
  logic [31:0]          data_reg;

  logic [IDX_W-1:0]     cand_idx [REQ_COUNT];
  logic [REQ_COUNT-1:0] cand_valid;
  logic                 rr_found;
  logic [IDX_W-1:0]     rr_pick;
  logic                 grant_en;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     owner_inc;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (int'(idx) == REQ_COUNT - 1) ? '0 : idx + IDX_W'(1);
  endfunction

  // Candidate gi is the requester gi positions after the round-robin pointer.
  generate
    for (genvar gi = 0; gi < REQ_COUNT; gi++) begin : g_cand
      assign cand_idx[gi]   = IDX_W'((int'(rr_ptr_reg) + gi) % REQ_COUNT);
      assign cand_valid[gi] = bus.req_valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    rr_found = 1'b0;
    rr_pick  = rr_ptr_reg;
    for (int k = REQ_COUNT - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        rr_found = 1'b1;
        rr_pick  = cand_idx[k];
      end
    end
  end

  // A full queue freezes arbitration entirely, including lock release.
  always_comb begin
    grant_en  = 1'b0;
    grant_idx = owner_reg;
    if (!bus.tx_full) begin
      if (state_reg == IDLE) begin
        grant_en  = rr_found;
        grant_idx = rr_pick;
      end else if (state_reg == LOCKED) begin
        grant_en  = bus.req_valid[owner_reg];
      end
    end
  end

  assign owner_inc = wrap_inc(owner_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
      lock_flag_reg <= 1'b0;
      push_reg      <= 1'b0;
      ack_reg       <= '0;
      command_reg   <= '0;
      data_reg      <= '0;
    end else begin
      push_reg <= 1'b0;
      ack_reg  <= '0;
      if (grant_en) begin
        state_reg     <= PUSH;
        owner_reg     <= grant_idx;
        lock_flag_reg <= bus.req_lock[grant_idx];
        command_reg   <= bus.req_command[grant_idx];
        data_reg      <= bus.req_data[grant_idx];
        push_reg      <= 1'b1;
        ack_reg       <= REQ_COUNT'(1) << grant_idx;
        if (bus.req_lock[grant_idx] && burst_cnt_reg != BURST_MAX) begin
          burst_cnt_reg <= burst_cnt_reg + CNT_W'(1);
        end
      end else begin
        case (state_reg)
          PUSH: begin
            if (!lock_flag_reg || burst_cnt_reg == BURST_MAX) begin
              state_reg     <= IDLE;
              rr_ptr_reg    <= owner_inc;
              burst_cnt_reg <= '0;
            end else begin
              state_reg  <= LOCKED;
              rr_ptr_reg <= owner_reg;
            end
          end
          LOCKED: begin
            if (!bus.tx_full && !bus.req_valid[owner_reg]) begin
              state_reg     <= IDLE;
              rr_ptr_reg    <= owner_inc;
              burst_cnt_reg <= '0;
            end
          end
          IDLE: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.tx_push_packet = push_reg;
  assign bus.req_ack        = ack_reg;
  assign bus.tx_command     = command_reg;
  assign bus.tx_data        = data_reg;
  assign bus.grant_owner    = owner_reg;
  assign bus.busy           = (state_reg != IDLE) || (|bus.req_valid);
endmodule

// File: tb/tb_hedios_tx_arbiter.sv
// Directed bench for hedios_tx_arbiter: a cycle table plus burst, full-stall and busy sequences.
module tb_hedios_tx_arbiter;
  localparam int N  = 2;
  localparam int NV = 39;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]       valid_drv;
  logic [N-1:0]       lock_drv;
  logic               full_drv;
  logic [N-1:0][7:0]  cmd_drv;
  logic [N-1:0][31:0] data_drv;

  hedios_tx_arbiter_if #(.REQ_COUNT(N)) bus_a ();
  hedios_tx_arbiter_if #(.REQ_COUNT(N)) bus_b ();

  assign bus_a.req_valid   = valid_drv;
  assign bus_a.req_lock    = lock_drv;
  assign bus_a.req_command = cmd_drv;
  assign bus_a.req_data    = data_drv;
  assign bus_a.tx_full     = full_drv;
  assign bus_b.req_valid   = valid_drv;
  assign bus_b.req_lock    = lock_drv;
  assign bus_b.req_command = cmd_drv;
  assign bus_b.req_data    = data_drv;
  assign bus_b.tx_full     = full_drv;

  hedios_tx_arbiter #(.REQ_COUNT(N), .MAX_BURST(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  hedios_tx_arbiter #(.REQ_COUNT(N), .MAX_BURST(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    logic       rst;
    logic [1:0] valid;
    logic [1:0] lock;
    logic       full;
    logic       exp_push;
    logic [1:0] exp_ack;
    logic       exp_owner;
  } vec_t;

  vec_t vecs [NV];
  int   errors = 0;
  int   checks = 0;
  int   pkt_cnt [N];
  int   own_a [4];
  int   own_b [4];
  int   cyc_a [4];
  int   n_a;
  int   n_b;
  int   exp_b [4];

  function automatic vec_t mk(int r, int v, int l, int f, int p, int a, int o);
    vec_t t;
    t.rst       = 1'(r);
    t.valid     = 2'(v);
    t.lock      = 2'(l);
    t.full      = 1'(f);
    t.exp_push  = 1'(p);
    t.exp_ack   = 2'(a);
    t.exp_owner = 1'(o);
    return t;
  endfunction

  function automatic logic [7:0] cmd_of(int i, int n);
    return 8'(i * 16 + n);
  endfunction

  function automatic logic [31:0] data_of(int i, int n);
    return 32'hA500_0000 | (32'(i) << 16) | 32'(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // columns: rst, valid, lock, full | push, ack, owner
    vecs[0]  = mk(0, 1, 0, 0, 1, 1, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 3, 0, 0, 1, 2, 1);
    vecs[4]  = mk(0, 3, 0, 0, 0, 0, 1);
    vecs[5]  = mk(0, 3, 0, 0, 1, 1, 0);
    vecs[6]  = mk(0, 3, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 3, 0, 0, 1, 2, 1);
    vecs[8]  = mk(0, 3, 0, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1);
    vecs[10] = mk(0, 1, 0, 1, 0, 0, 1);
    vecs[11] = mk(0, 1, 0, 1, 0, 0, 1);
    vecs[12] = mk(0, 1, 0, 0, 1, 1, 0);
    vecs[13] = mk(0, 1, 0, 1, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 3, 2, 0, 1, 2, 1);
    vecs[16] = mk(0, 3, 2, 0, 0, 0, 1);
    vecs[17] = mk(0, 3, 2, 0, 1, 2, 1);
    vecs[18] = mk(0, 3, 2, 0, 0, 0, 1);
    vecs[19] = mk(0, 3, 2, 0, 1, 2, 1);
    vecs[20] = mk(0, 3, 2, 0, 0, 0, 1);
    vecs[21] = mk(0, 3, 0, 0, 1, 2, 1);
    vecs[22] = mk(0, 3, 0, 0, 0, 0, 1);
    vecs[23] = mk(0, 3, 0, 0, 1, 1, 0);
    vecs[24] = mk(0, 3, 0, 0, 0, 0, 0);
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[26] = mk(0, 3, 2, 0, 1, 2, 1);
    vecs[27] = mk(0, 3, 2, 0, 0, 0, 1);
    vecs[28] = mk(0, 3, 2, 1, 0, 0, 1);
    vecs[29] = mk(0, 1, 0, 1, 0, 0, 1);
    vecs[30] = mk(0, 1, 0, 0, 0, 0, 1);
    vecs[31] = mk(0, 1, 0, 0, 1, 1, 0);
    vecs[32] = mk(0, 1, 0, 0, 0, 0, 0);
    vecs[33] = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[34] = mk(0, 3, 2, 0, 1, 2, 1);
    vecs[35] = mk(1, 3, 2, 0, 0, 0, 0);
    vecs[36] = mk(0, 3, 2, 0, 1, 1, 0);
    vecs[37] = mk(0, 3, 0, 0, 0, 0, 0);
    vecs[38] = mk(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < N; i++) pkt_cnt[i] = 0;

    // Reset state
    rst = 1'b1; valid_drv = '0; lock_drv = '0; full_drv = 1'b0;
    cmd_drv = '0; data_drv = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset push", 32'(bus_a.tx_push_packet), 32'd0);
    chk("reset ack", 32'(bus_a.req_ack), 32'd0);
    chk("reset owner", 32'(bus_a.grant_owner), 32'd0);
    chk("reset cmd", 32'(bus_a.tx_command), 32'd0);
    chk("reset data", bus_a.tx_data, 32'd0);
    chk("reset busy", 32'(bus_a.busy), 32'd0);

    for (int k = 0; k < NV; k++) begin
      int o;
      rst       = vecs[k].rst;
      valid_drv = vecs[k].valid;
      lock_drv  = vecs[k].lock;
      full_drv  = vecs[k].full;
      for (int i = 0; i < N; i++) begin
        cmd_drv[i]  = cmd_of(i, pkt_cnt[i]);
        data_drv[i] = data_of(i, pkt_cnt[i]);
      end
      @(posedge clk);
      #1;
      $display("vec %0d: push=%0b ack=%b owner=%0d cmd=%h data=%h", k,
               bus_a.tx_push_packet, bus_a.req_ack, bus_a.grant_owner,
               bus_a.tx_command, bus_a.tx_data);
      chk($sformatf("vec%0d push", k), 32'(bus_a.tx_push_packet), 32'(vecs[k].exp_push));
      chk($sformatf("vec%0d ack", k), 32'(bus_a.req_ack), 32'(vecs[k].exp_ack));
      chk($sformatf("vec%0d owner", k), 32'(bus_a.grant_owner), 32'(vecs[k].exp_owner));
      if (vecs[k].exp_push) begin
        o = int'(vecs[k].exp_owner);
        chk($sformatf("vec%0d cmd", k), 32'(bus_a.tx_command), 32'(cmd_of(o, pkt_cnt[o])));
        chk($sformatf("vec%0d data", k), bus_a.tx_data, data_of(o, pkt_cnt[o]));
      end
      if (vecs[k].rst) begin
        chk($sformatf("vec%0d rst cmd", k), 32'(bus_a.tx_command), 32'd0);
        chk($sformatf("vec%0d rst data", k), bus_a.tx_data, 32'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (vecs[k].exp_ack[i]) pkt_cnt[i]++;
      end
    end

    // Locked burst by req1 with req0 waiting: burst cap 16 vs cap 3
    rst = 1'b1; valid_drv = '0; lock_drv = '0; full_drv = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_drv = 2'b10;
    lock_drv  = 2'b10;
    n_a = 0;
    n_b = 0;
    for (int j = 0; j < 4; j++) begin
      own_a[j] = -1; own_b[j] = -1; cyc_a[j] = 0;
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus_a.tx_push_packet && n_a < 4) begin
        own_a[n_a] = int'(bus_a.grant_owner);
        cyc_a[n_a] = c;
        n_a++;
      end
      if (bus_b.tx_push_packet && n_b < 4) begin
        own_b[n_b] = int'(bus_b.grant_owner);
        n_b++;
      end
      valid_drv = 2'b11;
      if (n_a >= 4 && n_b >= 4) break;
    end
    $display("burst: cap16 owners %0d %0d %0d %0d, cap3 owners %0d %0d %0d %0d",
             own_a[0], own_a[1], own_a[2], own_a[3], own_b[0], own_b[1], own_b[2], own_b[3]);
    chk("burst16 push count", 32'(n_a), 32'd4);
    chk("burst3 push count", 32'(n_b), 32'd4);
    exp_b[0] = 1; exp_b[1] = 1; exp_b[2] = 1; exp_b[3] = 0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("burst16 owner%0d", j), 32'(own_a[j]), 32'd1);
      chk($sformatf("burst3 owner%0d", j), 32'(own_b[j]), 32'(exp_b[j]));
    end
    for (int j = 1; j < 4; j++) begin
      chk($sformatf("burst16 spacing%0d", j), 32'(cyc_a[j] - cyc_a[j-1]), 32'd2);
    end

    // Long full stall, then grant on the falling cycle; busy under reset and while locked
    rst = 1'b1; valid_drv = 2'b01; lock_drv = 2'b01; full_drv = 1'b1;
    cmd_drv[0] = 8'h12; data_drv[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("rst busy from valid", 32'(bus_a.busy), 32'd1);
    chk("rst push", 32'(bus_a.tx_push_packet), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      $display("stall %0d: push=%0b ack=%b", c, bus_a.tx_push_packet, bus_a.req_ack);
      chk($sformatf("stall%0d push", c), 32'(bus_a.tx_push_packet), 32'd0);
      chk($sformatf("stall%0d ack", c), 32'(bus_a.req_ack), 32'd0);
    end
    full_drv = 1'b0;
    @(posedge clk);
    #1;
    $display("unstall: push=%0b ack=%b cmd=%h data=%h", bus_a.tx_push_packet,
             bus_a.req_ack, bus_a.tx_command, bus_a.tx_data);
    chk("unstall push", 32'(bus_a.tx_push_packet), 32'd1);
    chk("unstall ack", 32'(bus_a.req_ack), 32'd1);
    chk("unstall cmd", 32'(bus_a.tx_command), 32'h12);
    chk("unstall data", bus_a.tx_data, 32'hDEAD_BEEF);
    chk("unstall owner", 32'(bus_a.grant_owner), 32'd0);
    @(posedge clk);
    #1;
    valid_drv = 2'b00;
    #1;
    chk("locked busy", 32'(bus_a.busy), 32'd1);
    chk("locked push", 32'(bus_a.tx_push_packet), 32'd0);
    @(posedge clk);
    #1;
    chk("released busy", 32'(bus_a.busy), 32'd0);
    chk("released push", 32'(bus_a.tx_push_packet), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
